// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding,
// default operand width and the counter-width helper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter width: max(1, clog2(width)); a 1-bit operand still needs a
  // legal 1-bit counter.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// Half subtractor: d = x - y (one bit), bo = borrow out.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are loaded on an accepted start,
// then one bit per cycle (LSB first) goes through a full-subtractor cell
// built from two half subtractors. The result is held after the done pulse
// until the next accepted start.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] diff_nxt;
  logic [CW-1:0]    cnt;
  logic             load, shift;

  // Full-subtractor cell on the operand LSBs and the stored borrow.
  logic d0, bo0, d, bo1, bout;

  half_sub u_hs0 (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .d  (d0),
    .bo (bo0)
  );

  half_sub u_hs1 (
    .x  (d0),
    .y  (borrow),
    .d  (d),
    .bo (bo1)
  );

  assign bout = bo0 | bo1;

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) result bit has landed in bit 0.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_nxt = d;
    end else begin : g_diff_wn
      assign diff_nxt = {d, diff[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on acceptance, shift one bit per SHIFT cycle.
  // diff/borrow are left untouched outside SHIFT so they hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      diff   <= diff_nxt;
      borrow <= bout;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 and a WIDTH=1 instance, a
// cycle-level transaction model checked every cycle, plus directed
// vectors with literal expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: an accepted start makes the unit busy for WIDTH+1
  // cycles, the last of which is the done cycle carrying (a-b) mod 2^W and
  // a<b. Results then hold until reset or the next done.
  int          mw[2]   = '{8, 1};
  logic [31:0] mask[2] = '{32'hFF, 32'h1};
  int          rem[2]  = '{0, 0};
  logic [31:0] ea[2], eb[2], res_d[2], res_b[2];
  logic        m_st[2];
  logic [31:0] m_a[2], m_b[2];

  always @(posedge clk) begin
    m_st[0] = start8; m_a[0] = {24'b0, a8}; m_b[0] = {24'b0, b8};
    m_st[1] = start1; m_a[1] = {31'b0, a1}; m_b[1] = {31'b0, b1};
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        rem[m]   = 0;
        res_d[m] = 0;
        res_b[m] = 0;
      end else if (rem[m] == 0 && m_st[m]) begin
        rem[m] = mw[m] + 1;
        ea[m]  = m_a[m];
        eb[m]  = m_b[m];
      end else if (rem[m] > 0) begin
        rem[m]--;
        if (rem[m] == 1) begin
          res_d[m] = (ea[m] - eb[m]) & mask[m];
          res_b[m] = {31'b0, ea[m] < eb[m]};
        end
      end
    end
  end

  // Compare process: busy/done every cycle; diff/borrow only when valid.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8 busy", {31'b0, busy8}, {31'b0, rem[0] > 0});
      chk("m8 done", {31'b0, done8}, {31'b0, rem[0] == 1});
      if (rem[0] <= 1) begin
        chk("m8 diff", {24'b0, diff8}, res_d[0]);
        chk("m8 borrow", {31'b0, borrow8}, res_b[0]);
      end
      chk("m1 busy", {31'b0, busy1}, {31'b0, rem[1] > 0});
      chk("m1 done", {31'b0, done1}, {31'b0, rem[1] == 1});
      if (rem[1] <= 1) begin
        chk("m1 diff", {31'b0, diff1}, res_d[1]);
        chk("m1 borrow", {31'b0, borrow1}, res_b[1]);
      end
    end
  end

  // One WIDTH=8 operation, entered at a negedge with the unit idle.
  // Operands are scrambled after acceptance to show they are not re-sampled.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] d, output logic bo,
                     output int lat, output int bcnt);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1; bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy8) bcnt++;
    end
    d = diff8; bo = borrow8;
    @(negedge clk);
  endtask

  task automatic op1(input logic a, input logic b,
                     output logic d, output logic bo, output int lat);
    a1 = a; b1 = b; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a; b1 = ~b;
    lat = 1;
    while (!done1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = diff1[0]; bo = borrow1;
    @(negedge clk);
  endtask

  logic [7:0] d8, ra, rb;
  logic       bo8, d1v, bo1v;
  int         lat, bcnt, nd, cyc, ndone;
  int         t[3];
  logic [1:0] tv_a[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] tv_b[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] tv_d[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] tv_bo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy8", {31'b0, busy8}, 32'd0);
    chk("reset done8", {31'b0, done8}, 32'd0);
    chk("reset diff8", {24'b0, diff8}, 32'd0);
    chk("reset borrow8", {31'b0, borrow8}, 32'd0);
    chk("reset diff1", {31'b0, diff1}, 32'd0);
    chk_en = 1'b1;

    // Start presented together with reset release: accepted on first edge.
    rst = 1'b0;
    op8(8'h35, 8'h12, d8, bo8, lat, bcnt);
    chk("v1 latency", lat, 32'd9);
    chk("v1 busy cycles", bcnt, 32'd9);
    chk("v1 diff", {24'b0, d8}, 32'h23);
    chk("v1 borrow", {31'b0, bo8}, 32'd0);

    op8(8'h00, 8'h01, d8, bo8, lat, bcnt);
    chk("v2 diff", {24'b0, d8}, 32'hFF);
    chk("v2 borrow", {31'b0, bo8}, 32'd1);
    op8(8'hAA, 8'hAA, d8, bo8, lat, bcnt);
    chk("v3 diff", {24'b0, d8}, 32'h00);
    chk("v3 borrow", {31'b0, bo8}, 32'd0);

    // start held high: back-to-back ops every WIDTH+2 cycles; operands
    // are garbage whenever the unit is busy.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        t[nd] = cyc;
        chk("cont diff", {24'b0, diff8}, 32'h0F);
        chk("cont borrow", {31'b0, borrow8}, 32'd0);
        nd++;
      end
      if (busy8) begin a8 = 8'hFF; b8 = 8'hFE; end
      else       begin a8 = 8'h10; b8 = 8'h01; end
    end
    start8 = 1'b0;
    @(negedge clk);
    chk("cont done count", nd, 32'd3);
    chk("cont gap1", t[1] - t[0], 32'd10);
    chk("cont gap2", t[2] - t[1], 32'd10);

    // Reset in the middle of an operation.
    a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy8}, 32'd0);
    chk("midrst diff", {24'b0, diff8}, 32'd0);
    chk("midrst borrow", {31'b0, borrow8}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("midrst no done", ndone, 32'd0);
    op8(8'h80, 8'h7F, d8, bo8, lat, bcnt);
    chk("postrst diff", {24'b0, d8}, 32'h01);
    chk("postrst borrow", {31'b0, bo8}, 32'd0);
    chk("postrst latency", lat, 32'd9);

    // Random operand pairs.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb, d8, bo8, lat, bcnt);
      chk("rand diff", {24'b0, d8}, {24'b0, 8'(ra - rb)});
      chk("rand borrow", {31'b0, bo8}, {31'b0, ra < rb});
    end

    // WIDTH=1 half-subtractor truth table.
    for (int i = 0; i < 4; i++) begin
      op1(tv_a[i][0], tv_b[i][0], d1v, bo1v, lat);
      chk("w1 diff", {31'b0, d1v}, {31'b0, tv_d[i][0]});
      chk("w1 borrow", {31'b0, bo1v}, {31'b0, tv_bo[i][0]});
      chk("w1 latency", lat, 32'd2);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction, sampled on each rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits, the unsigned minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, the unsigned subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking that the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits, the result a - b mod 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1 bit, the final borrow-out, which is 1 iff a < b (unsigned).

Function
REQ-011 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL load a and b into operand shift registers, clear the borrow flop and the bit counter, and enter SHIFT; this is the acceptance cycle.
REQ-013 The block SHALL accept start only in IDLE and SHALL ignore it in SHIFT and DONE, with no effect on the operation in progress.
REQ-014 In each SHIFT cycle, the block SHALL compute d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin) from the operand LSBs and the borrow flop.
REQ-015 In each SHIFT cycle, the block SHALL shift d into the MSB of the diff register, shift both operands right by 1, store bout in the borrow flop, and increment the counter.
REQ-016 When the counter equals WIDTH-1 in SHIFT, the block SHALL process that final bit and then enter DONE.
REQ-017 The block SHALL spend exactly WIDTH cycles in SHIFT; done SHALL be high in the (WIDTH+1)th cycle after the acceptance edge.
REQ-018 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-019 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-020 diff and borrow SHALL be valid from the done cycle and SHALL hold until the next accepted start.
REQ-021 diff and borrow contents while busy SHALL be unspecified, and benches SHALL NOT check them during that interval.
REQ-022 A start asserted in the DONE cycle SHALL be ignored; a start asserted in the following IDLE cycle SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-023 With WIDTH=1, diff and borrow SHALL equal the half-subtractor truth table.

Reset
REQ-024 When rst=1 at an edge, the block SHALL return to IDLE and clear busy, done, diff, borrow, the counter and the operand registers to 0.
REQ-025 rst SHALL take priority over start, and reset mid-operation SHALL abandon the operation with no done pulse.
REQ-026 start SHALL be accepted on the first edge with rst=0.

Structure
REQ-027 The FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH SHALL reside in the shared arithmetic definitions include file.
REQ-028 Per-bit logic SHALL be two instances of sub-module half_sub (inputs x, y; outputs d, bo) combined with an OR to form the full-subtractor cell.
REQ-029 The counter width SHALL be max(1, clog2(WIDTH)).

Verification
REQ-030 WIDTH=8, a=0x35, b=0x12, start for 1 cycle -> done 9 cycles after acceptance, diff=0x23, borrow=0; busy high for 9 cycles.
REQ-031 WIDTH=8, a=0x00, b=0x01 -> diff=0xFF, borrow=1; then a=0xAA, b=0xAA -> diff=0x00, borrow=0.
REQ-032 WIDTH=8: start held high continuously with a=0x10, b=0x01 -> results 0x0F, borrow 0, at done pulses spaced exactly 10 cycles apart; operand changes while busy have no effect.
REQ-033 WIDTH=8: rst pulsed 4 cycles after acceptance -> busy=0, diff=0, borrow=0 next cycle, no done pulse; a new start completes correctly.
REQ-034 WIDTH=1, all four (a,b) pairs -> (diff,borrow) = (0,0), (1,1), (1,0), (0,0) for (0,0), (0,1), (1,0), (1,1), with done 2 cycles after each acceptance.
REQ-035 Random: 1000 random WIDTH=8 operand pairs -> diff == (a-b) mod 256 and borrow == (a<b) at every done pulse.
